// File: rtl/round_sequencer.sv
// Blackjack round controller. It deals four cards, then runs the player turn and the
// dealer turn. The outcome is registered when the round enters DONE.
module round_sequencer #(
   parameter int DEALER_STAND = 17,
   parameter bit HIT_SOFT     = 1'b0
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       START_I,
   input  logic       HIT_I,
   input  logic       STAY_I,
   output logic       CARD_REQ_O,
   input  logic       CARD_VLD_I,
   input  logic [3:0] CARD_I,
   output logic [4:0] PLAYER_TOTAL_O,
   output logic [4:0] DEALER_TOTAL_O,
   output logic [2:0] PHASE_O,
   output logic       WIN_O,
   output logic       TIE_O,
   output logic       LOSE_O
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      DEAL   = 3'd1,
      PLAYER = 3'd2,
      P_DRAW = 3'd3,
      DEALER = 3'd4,
      D_DRAW = 3'd5,
      DONE   = 3'd6
   } state_e;

   localparam logic [4:0] STAND = 5'(DEALER_STAND);

   function automatic logic [4:0] card_value(input logic [3:0] c);
      return (c >= 4'd10) ? 5'd10 : {1'b0, c};
   endfunction

   // Hard sums saturate at 31 so a long bust run can never wrap back under 21.
   function automatic logic [4:0] add_sat(input logic [4:0] h, input logic [4:0] v);
      logic [5:0] s;
      s = {1'b0, h} + {1'b0, v};
      return (s > 6'd31) ? 5'd31 : s[4:0];
   endfunction

   function automatic logic [4:0] best_total(input logic [4:0] h, input logic ace);
      return (ace && h <= 5'd11) ? h + 5'd10 : h;
   endfunction

   state_e     state_q, state_d;
   logic [4:0] p_hard_q, p_hard_d, d_hard_q, d_hard_d;
   logic       p_ace_q, p_ace_d, d_ace_q, d_ace_d;
   logic [4:0] p_total_q, p_total_d, d_total_q, d_total_d;
   logic [1:0] deal_cnt_q, deal_cnt_d;
   logic       card_req_q, card_req_d;
   logic       win_q, win_d, tie_q, tie_d, lose_q, lose_d;

   logic       accept;
   logic       is_ace;
   logic [4:0] card_val;
   logic       d_soft;

   assign accept   = card_req_q && CARD_VLD_I && (CARD_I != 4'd0);
   assign is_ace   = (CARD_I == 4'd1);
   assign card_val = card_value(CARD_I);
   assign d_soft   = d_ace_q && (d_hard_q <= 5'd11);

   always_comb begin
      // NOTE: every _d gets its hold value first, so no path through the case infers a latch.
      state_d    = state_q;
      p_hard_d   = p_hard_q;
      d_hard_d   = d_hard_q;
      p_ace_d    = p_ace_q;
      d_ace_d    = d_ace_q;
      deal_cnt_d = deal_cnt_q;
      card_req_d = card_req_q;
      win_d      = win_q;
      tie_d      = tie_q;
      lose_d     = lose_q;

      case (state_q)
         IDLE, DONE: begin
            if (START_I) begin
               state_d    = DEAL;
               p_hard_d   = 5'd0;
               d_hard_d   = 5'd0;
               p_ace_d    = 1'b0;
               d_ace_d    = 1'b0;
               deal_cnt_d = 2'd0;
               card_req_d = 1'b1;
               win_d      = 1'b0;
               tie_d      = 1'b0;
               lose_d     = 1'b0;
            end
         end
         DEAL: begin
            if (accept) begin
               deal_cnt_d = deal_cnt_q + 2'd1;
               if (!deal_cnt_q[0]) begin
                  p_hard_d = add_sat(p_hard_q, card_val);
                  p_ace_d  = p_ace_q | is_ace;
               end else begin
                  d_hard_d = add_sat(d_hard_q, card_val);
                  d_ace_d  = d_ace_q | is_ace;
               end
               // The fourth card goes to the dealer, so the player total is already final here.
               if (deal_cnt_q == 2'd3) begin
                  card_req_d = 1'b0;
                  state_d    = (p_total_q == 5'd21) ? DEALER : PLAYER;
               end
            end
         end
         PLAYER: begin
            if (STAY_I) begin
               state_d = DEALER;
            end else if (HIT_I) begin
               state_d    = P_DRAW;
               card_req_d = 1'b1;
            end
         end
         P_DRAW: begin
            if (accept) begin
               p_hard_d   = add_sat(p_hard_q, card_val);
               p_ace_d    = p_ace_q | is_ace;
               card_req_d = 1'b0;
               if (p_hard_d > 5'd21) begin
                  state_d = DONE;
                  lose_d  = 1'b1;
               end else if (best_total(p_hard_d, p_ace_d) == 5'd21) begin
                  state_d = DEALER;
               end else begin
                  state_d = PLAYER;
               end
            end
         end
         DEALER: begin
            if (d_total_q < STAND || (d_total_q == STAND && d_soft && HIT_SOFT)) begin
               state_d    = D_DRAW;
               card_req_d = 1'b1;
            end else begin
               state_d = DONE;
               if (d_hard_q > 5'd21 || p_total_q > d_total_q) win_d = 1'b1;
               else if (p_total_q == d_total_q)               tie_d = 1'b1;
               else                                           lose_d = 1'b1;
            end
         end
         D_DRAW: begin
            if (accept) begin
               d_hard_d   = add_sat(d_hard_q, card_val);
               d_ace_d    = d_ace_q | is_ace;
               card_req_d = 1'b0;
               state_d    = DEALER;
            end
         end
         default: state_d = IDLE;
      endcase

      p_total_d = best_total(p_hard_d, p_ace_d);
      d_total_d = best_total(d_hard_d, d_ace_d);
   end

   // NOTE: state updates use non-blocking assignments so all flops sample the same pre-edge values.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= IDLE;
         p_hard_q   <= 5'd0;
         d_hard_q   <= 5'd0;
         p_ace_q    <= 1'b0;
         d_ace_q    <= 1'b0;
         p_total_q  <= 5'd0;
         d_total_q  <= 5'd0;
         deal_cnt_q <= 2'd0;
         card_req_q <= 1'b0;
         win_q      <= 1'b0;
         tie_q      <= 1'b0;
         lose_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         p_hard_q   <= p_hard_d;
         d_hard_q   <= d_hard_d;
         p_ace_q    <= p_ace_d;
         d_ace_q    <= d_ace_d;
         p_total_q  <= p_total_d;
         d_total_q  <= d_total_d;
         deal_cnt_q <= deal_cnt_d;
         card_req_q <= card_req_d;
         win_q      <= win_d;
         tie_q      <= tie_d;
         lose_q     <= lose_d;
      end
   end

   assign CARD_REQ_O     = card_req_q;
   assign PLAYER_TOTAL_O = p_total_q;
   assign DEALER_TOTAL_O = d_total_q;
   assign PHASE_O        = state_q;
   assign WIN_O          = win_q;
   assign TIE_O          = tie_q;
   assign LOSE_O         = lose_q;

endmodule

// File: tb/tb_round_sequencer.sv
// Bench for round_sequencer. A card-list model of blackjack predicts totals, phases and outcomes
// for directed and randomized rounds. A second instance with HIT_SOFT = 1 covers the soft-17 rule.
module tb_round_sequencer;

   localparam int PH_IDLE = 0, PH_DEAL = 1, PH_PLAYER = 2, PH_P_DRAW = 3,
                  PH_DEALER = 4, PH_D_DRAW = 5, PH_DONE = 6;

   logic       CLK = 1'b0;
   logic       RST, START_I, HIT_I, STAY_I, CARD_VLD_I;
   logic [3:0] CARD_I;

   logic       req_a, win_a, tie_a, lose_a;
   logic [4:0] pt_a, dt_a;
   logic [2:0] phase_a;
   logic       req_b, win_b, tie_b, lose_b;
   logic [4:0] pt_b, dt_b;
   logic [2:0] phase_b;

   int n_checks = 0;
   int n_fails  = 0;
   int pc[$];
   int dc[$];

   always #5 CLK = ~CLK;

   round_sequencer #(.DEALER_STAND(17), .HIT_SOFT(1'b0)) u_dut (
      .CLK(CLK), .RST(RST), .START_I(START_I), .HIT_I(HIT_I), .STAY_I(STAY_I),
      .CARD_REQ_O(req_a), .CARD_VLD_I(CARD_VLD_I), .CARD_I(CARD_I),
      .PLAYER_TOTAL_O(pt_a), .DEALER_TOTAL_O(dt_a), .PHASE_O(phase_a),
      .WIN_O(win_a), .TIE_O(tie_a), .LOSE_O(lose_a)
   );

   round_sequencer #(.DEALER_STAND(17), .HIT_SOFT(1'b1)) u_dut_soft (
      .CLK(CLK), .RST(RST), .START_I(START_I), .HIT_I(HIT_I), .STAY_I(STAY_I),
      .CARD_REQ_O(req_b), .CARD_VLD_I(CARD_VLD_I), .CARD_I(CARD_I),
      .PLAYER_TOTAL_O(pt_b), .DEALER_TOTAL_O(dt_b), .PHASE_O(phase_b),
      .WIN_O(win_b), .TIE_O(tie_b), .LOSE_O(lose_b)
   );

   // ---------------- reference model: hands as card lists ----------------
   function automatic int cval(input int c);
      return (c >= 10) ? 10 : c;
   endfunction

   function automatic int hard_of(input int q[$]);
      int s = 0;
      foreach (q[i]) s += cval(q[i]);
      return (s > 31) ? 31 : s;
   endfunction

   function automatic bit ace_of(input int q[$]);
      foreach (q[i]) if (q[i] == 1) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit soft_of(input int q[$]);
      return ace_of(q) && hard_of(q) <= 11;
   endfunction

   function automatic int best_of(input int q[$]);
      return soft_of(q) ? hard_of(q) + 10 : hard_of(q);
   endfunction

   function automatic bit dealer_hits(input int q[$], input bit hit_soft);
      int b = best_of(q);
      return (b < 17) || (b == 17 && soft_of(q) && hit_soft);
   endfunction

   // 3'b100 win, 3'b010 tie, 3'b001 lose
   function automatic int outcome_of(input int p[$], input int d[$]);
      if (hard_of(p) > 21) return 3'b001;
      if (hard_of(d) > 21) return 3'b100;
      if (best_of(p) > best_of(d)) return 3'b100;
      if (best_of(p) == best_of(d)) return 3'b010;
      return 3'b001;
   endfunction

   // ---------------- helpers ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check_totals(input string tag);
      chk({tag, "_player_total"}, pt_a, best_of(pc));
      chk({tag, "_dealer_total"}, dt_a, best_of(dc));
   endtask

   // Supplies one card once the DUT asks, with optional idle stalls (random junk on the
   // player/start inputs, which must be ignored there) and an optional invalid zero code first.
   task automatic give_card(input int c, input int stall, input bit zero_first);
      int guard = 0;
      while (req_a !== 1'b1 && guard < 20) begin
         tick();
         guard++;
      end
      if (req_a !== 1'b1) chk("card_req_timeout", req_a, 1);
      repeat (stall) begin
         CARD_VLD_I = 1'b0;
         HIT_I      = 1'($urandom_range(0, 1));
         STAY_I     = 1'($urandom_range(0, 1));
         START_I    = 1'($urandom_range(0, 1));
         tick();
         chk("req_hold_stall", req_a, 1);
      end
      HIT_I   = 1'b0;
      STAY_I  = 1'b0;
      START_I = 1'b0;
      if (zero_first) begin
         CARD_VLD_I = 1'b1;
         CARD_I     = 4'd0;
         tick();
         chk("req_hold_zero_card", req_a, 1);
      end
      CARD_VLD_I = 1'b1;
      CARD_I     = c[3:0];
      tick();
      CARD_VLD_I = 1'b0;
      CARD_I     = 4'd0;
   endtask

   task automatic start_round();
      pc.delete();
      dc.delete();
      START_I = 1'b1;
      tick();
      START_I = 1'b0;
      chk("start_phase", phase_a, PH_DEAL);
      chk("start_req", req_a, 1);
      chk("start_flags_clear", {win_a, tie_a, lose_a}, 0);
      check_totals("start");
   endtask

   task automatic deal4(input int c0, input int c1, input int c2, input int c3);
      int cards[4];
      cards = '{c0, c1, c2, c3};
      for (int i = 0; i < 4; i++) begin
         give_card(cards[i], 0, 1'b0);
         if (i % 2 == 0) pc.push_back(cards[i]);
         else            dc.push_back(cards[i]);
      end
      check_totals("deal");
      chk("deal_req_drop", req_a, 0);
   endtask

   task automatic pulse(input bit hit, input bit stay);
      HIT_I  = hit;
      STAY_I = stay;
      tick();
      HIT_I  = 1'b0;
      STAY_I = 1'b0;
   endtask

   task automatic play_random_round();
      int  c;
      bit  in_player, p_bust, hit, both;
      start_round();
      for (int i = 0; i < 4; i++) begin
         c = $urandom_range(1, 15);
         give_card(c, $urandom_range(0, 2), ($urandom_range(0, 3) == 0));
         if (i % 2 == 0) pc.push_back(c);
         else            dc.push_back(c);
         check_totals("rnd_deal");
      end
      chk("rnd_deal_req_drop", req_a, 0);
      in_player = (best_of(pc) != 21);
      p_bust    = 1'b0;
      chk("rnd_after_deal_phase", phase_a, in_player ? PH_PLAYER : PH_DEALER);
      while (in_player) begin
         hit  = ($urandom_range(0, 99) < ((best_of(pc) < 17) ? 75 : 25));
         both = ($urandom_range(0, 5) == 0);
         if (!hit || both) begin
            pulse(both, 1'b1);
            chk("rnd_stay_phase", phase_a, PH_DEALER);
            chk("rnd_stay_no_req", req_a, 0);
            in_player = 1'b0;
         end else begin
            pulse(1'b1, 1'b0);
            chk("rnd_hit_phase", phase_a, PH_P_DRAW);
            chk("rnd_hit_req", req_a, 1);
            c = $urandom_range(1, 15);
            give_card(c, $urandom_range(0, 2), ($urandom_range(0, 3) == 0));
            pc.push_back(c);
            check_totals("rnd_hit");
            chk("rnd_hit_req_drop", req_a, 0);
            if (hard_of(pc) > 21) begin
               chk("rnd_bust_phase", phase_a, PH_DONE);
               p_bust    = 1'b1;
               in_player = 1'b0;
            end else if (best_of(pc) == 21) begin
               chk("rnd_21_phase", phase_a, PH_DEALER);
               in_player = 1'b0;
            end else begin
               chk("rnd_back_phase", phase_a, PH_PLAYER);
            end
         end
      end
      if (!p_bust) begin
         while (dealer_hits(dc, 1'b0)) begin
            tick();
            chk("rnd_dealer_draw_phase", phase_a, PH_D_DRAW);
            chk("rnd_dealer_req", req_a, 1);
            c = $urandom_range(1, 15);
            give_card(c, $urandom_range(0, 2), ($urandom_range(0, 3) == 0));
            dc.push_back(c);
            check_totals("rnd_dealer");
            chk("rnd_dealer_back_phase", phase_a, PH_DEALER);
         end
         tick();
         chk("rnd_done_phase", phase_a, PH_DONE);
      end
      chk("rnd_outcome", {win_a, tie_a, lose_a}, outcome_of(pc, dc));
      chk("rnd_done_no_req", req_a, 0);
      tick();
      chk("rnd_outcome_hold", {win_a, tie_a, lose_a}, outcome_of(pc, dc));
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      RST = 1'b1; START_I = 1'b0; HIT_I = 1'b0; STAY_I = 1'b0;
      CARD_VLD_I = 1'b0; CARD_I = 4'd0;
      tick();
      tick();
      RST = 1'b0;
      repeat (5) tick();
      chk("reset_phase", phase_a, PH_IDLE);
      chk("reset_req", req_a, 0);
      chk("reset_totals", {pt_a, dt_a}, 0);
      chk("reset_flags", {win_a, tie_a, lose_a}, 0);

      // Player soft 21 skips the player turn; dealer 11 draws to 20.
      start_round();
      deal4(10, 6, 1, 5);
      chk("bj_player_21", pt_a, 21);
      chk("bj_phase_dealer", phase_a, PH_DEALER);
      tick();
      chk("bj_dealer_draw", phase_a, PH_D_DRAW);
      chk("bj_dealer_req", req_a, 1);
      give_card(9, 0, 1'b0);
      dc.push_back(9);
      chk("bj_dealer_20", dt_a, 20);
      chk("bj_back_dealer", phase_a, PH_DEALER);
      tick();
      chk("bj_done", phase_a, PH_DONE);
      chk("bj_win", {win_a, tie_a, lose_a}, 3'b100);

      // Player busts: lose at once, dealer never draws. START mid-round is ignored.
      start_round();
      deal4(10, 10, 5, 7);
      chk("bust_phase_player", phase_a, PH_PLAYER);
      START_I = 1'b1;
      tick();
      START_I = 1'b0;
      chk("start_ignored_phase", phase_a, PH_PLAYER);
      check_totals("start_ignored");
      pulse(1'b1, 1'b0);
      chk("bust_p_draw", phase_a, PH_P_DRAW);
      give_card(9, 0, 1'b0);
      pc.push_back(9);
      chk("bust_player_24", pt_a, 24);
      chk("bust_done", phase_a, PH_DONE);
      chk("bust_lose", {win_a, tie_a, lose_a}, 3'b001);
      repeat (3) begin
         tick();
         chk("bust_no_req", req_a, 0);
      end

      // Soft 17: standard instance stands (tie), soft-hit instance draws.
      RST = 1'b1;
      tick();
      RST = 1'b0;
      start_round();
      deal4(9, 1, 8, 6);
      chk("soft17_dealer", dt_a, 17);
      pulse(1'b0, 1'b1);
      chk("soft17_dealer_phase_a", phase_a, PH_DEALER);
      chk("soft17_dealer_phase_b", phase_b, PH_DEALER);
      tick();
      chk("soft17_stand_done", phase_a, PH_DONE);
      chk("soft17_tie", {win_a, tie_a, lose_a}, outcome_of(pc, dc));
      chk("soft17_hit_phase_b", phase_b, PH_D_DRAW);
      chk("soft17_hit_req_b", req_b, 1);
      RST = 1'b1;
      tick();
      RST = 1'b0;

      // Stalled and invalid cards, then simultaneous hit/stay, then reset during a draw.
      start_round();
      deal4(2, 3, 2, 3);
      pulse(1'b1, 1'b0);
      give_card(4, 3, 1'b1);
      pc.push_back(4);
      chk("stall_player_8", pt_a, 8);
      chk("stall_req_drop", req_a, 0);
      chk("stall_phase_player", phase_a, PH_PLAYER);
      pulse(1'b1, 1'b1);
      chk("both_phase_dealer", phase_a, PH_DEALER);
      chk("both_no_card", pt_a, best_of(pc));
      tick();
      chk("rst_pre_req", req_a, 1);
      RST = 1'b1;
      CARD_VLD_I = 1'b1;
      CARD_I = 4'd5;
      tick();
      RST = 1'b0;
      CARD_VLD_I = 1'b0;
      CARD_I = 4'd0;
      chk("rst_draw_req", req_a, 0);
      chk("rst_draw_phase", phase_a, PH_IDLE);
      chk("rst_draw_totals", {pt_a, dt_a}, 0);

      repeat (40) play_random_round();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule

// File: doc/round_sequencer.md
ROUND_SEQUENCER -- requirements
Module: round_sequencer

Interface
REQ-001 Parameter DEALER_STAND, default 17: dealer stands when its best total is >= this value.
REQ-002 Parameter HIT_SOFT, default 0: when 1, dealer draws on soft DEALER_STAND; when 0, dealer stands on it.
REQ-003 CLK  in  1  single clock; all state changes on rising edge.
REQ-004 RST  in  1  synchronous, active-high reset.
REQ-005 START_I  in  1  begin a round; honoured only in IDLE or DONE.
REQ-006 HIT_I  in  1  player requests a card; honoured only in PLAYER.
REQ-007 STAY_I  in  1  player ends turn; honoured only in PLAYER.
REQ-008 CARD_REQ_O  out  1  request one card from the card source.
REQ-009 CARD_VLD_I  in  1  card source: CARD_I valid this cycle.
REQ-010 CARD_I  in  4  card code: 1 = ace, 2..9 face value, 10..15 = ten-value, 0 = invalid.
REQ-011 PLAYER_TOTAL_O  out  5  player best total, registered.
REQ-012 DEALER_TOTAL_O  out  5  dealer best total, registered.
REQ-013 PHASE_O  out  3  current state encoding: IDLE=0, DEAL=1, PLAYER=2, P_DRAW=3, DEALER=4, D_DRAW=5, DONE=6.
REQ-014 WIN_O, TIE_O, LOSE_O  out  1 each  registered round outcome; at most one high.

Function
REQ-015 A card is accepted only on an edge where CARD_REQ_O and CARD_VLD_I are both 1; CARD_REQ_O is 0 from the following cycle until the next draw.
REQ-016 CARD_REQ_O stays high while CARD_VLD_I is low; a valid cycle with CARD_I = 0 is discarded and CARD_REQ_O stays high.
REQ-017 Each hand is tracked as a 5-bit hard sum (ace = 1, ten-value = 10) plus an ace-seen flag.
REQ-018 Best total = hard + 10 when ace-seen and hard <= 11; otherwise best total = hard.
REQ-019 A hand is soft when the +10 is applied; a hand is bust when hard > 21.
REQ-020 IDLE/DONE + START_I -> DEAL: clear totals and outcome flags; raise CARD_REQ_O on the same edge.
REQ-021 DEAL accepts four cards in order player, dealer, player, dealer, tracked by a 2-bit counter.
REQ-022 After the fourth card: player best = 21 -> DEALER; otherwise -> PLAYER.
REQ-023 PLAYER: STAY_I -> DEALER; HIT_I -> P_DRAW with CARD_REQ_O raised.
REQ-024 In PLAYER, STAY_I has priority when HIT_I and STAY_I are high together.
REQ-025 P_DRAW, on card accept: bust -> DONE with LOSE_O = 1 (dealer does not draw); best = 21 -> DEALER; otherwise -> PLAYER.
REQ-026 HIT_I and STAY_I are ignored in every state except PLAYER, including while a draw is pending.
REQ-027 DEALER, evaluated in one cycle: draw if best < DEALER_STAND, or if best == DEALER_STAND, soft, and HIT_SOFT = 1 -> D_DRAW with CARD_REQ_O raised; otherwise -> DONE.
REQ-028 D_DRAW, on card accept -> DEALER.
REQ-029 Entering DONE from DEALER: dealer bust -> WIN; player > dealer -> WIN; equal -> TIE; else LOSE.
REQ-030 Outcome flags are valid in the first DONE cycle and hold until START_I or RST.
REQ-031 Totals update on the accepting edge; the hard sum never exceeds 31 (no wrap).
REQ-032 START_I outside IDLE/DONE is ignored; the round continues unaffected.

Reset
REQ-033 RST = 1 at a rising edge forces, on that edge: PHASE_O = IDLE, CARD_REQ_O = 0, totals = 0, WIN_O/TIE_O/LOSE_O = 0, deal counter = 0, ace flags = 0.
REQ-034 RST during a pending draw abandons the draw; a CARD_VLD_I in the reset cycle is ignored.

Verification
REQ-035 Reset, then idle 5 cycles -> all outputs 0, PHASE_O = 0, no CARD_REQ_O.
REQ-036 START_I; cards 10, 6, 1, 5 -> player soft 21, PHASE_O skips PLAYER to DEALER; dealer hard 11 draws 9 -> 20, stands -> WIN_O = 1, totals 21/20.
REQ-037 Deal 10, 10, 5, 7 (player 15, dealer 17); HIT_I; card 9 -> player 24, DONE, LOSE_O = 1, no further CARD_REQ_O.
REQ-038 Deal 9, 1, 8, 6 (player 17, dealer soft 17) -> HIT_SOFT = 0: stand, STAY_I -> TIE_O = 1; HIT_SOFT = 1: dealer requests another card.
REQ-039 CARD_VLD_I held low 3 cycles, then CARD_I = 0, then 4 -> CARD_REQ_O high throughout; only the 4 is counted; REQ drops the next cycle.
REQ-040 In PLAYER, HIT_I and STAY_I together -> DEALER, no player card drawn; RST asserted while CARD_REQ_O is high -> CARD_REQ_O = 0 and PHASE_O = 0 on that edge.
